// File: rtl/note_recorder_if.sv
// note_recorder_if: signal bundle between note_recorder and its controller
// master: drives start/abort/beat_clk/buttons, reads patterns and status
// slave:  the recorder itself
interface note_recorder_if;
  logic start, abort, beat_clk, button_1, button_2;
  logic [31:0] notes1, notes2;
  logic [7:0] count_1, count_2;
  logic [4:0] beat_idx;
  logic recording, done, notes_valid;
  modport master (
    output start, abort, beat_clk, button_1, button_2,
    input  notes1, notes2, count_1, count_2, beat_idx, recording, done, notes_valid
  );
  modport slave (
    input  start, abort, beat_clk, button_1, button_2,
    output notes1, notes2, count_1, count_2, beat_idx, recording, done, notes_valid
  );
endinterface

// File: rtl/note_recorder.sv
// note_recorder: two-lane, 32-beat button pattern recorder with BCD note counts
// Ports: clk; n_rst async active-low reset; bus (slave) carries
//   in:  start, abort, beat_clk, button_1, button_2
//   out: notes1/notes2 (bit 31 = first beat), count_1/count_2 (BCD),
//        beat_idx, recording, done, notes_valid
module note_recorder (
  input logic clk,
  input logic n_rst,
  note_recorder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, RECORD, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] sync1_q, sync2_q, hist_q, press_q, warm_q;
  logic [1:0] pend_q, pend_d;
  logic [31:0] notes1_q, notes1_d, notes2_q, notes2_d;
  logic [7:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [4:0] idx_q, idx_d;
  logic valid_q, valid_d;
  logic last_beat;

  function automatic logic [7:0] bcd_inc(input logic [7:0] c);
    return (c[3:0] == 4'd9) ? {c[7:4] + 4'd1, 4'd0} : c + 8'd1;
  endfunction

  // Edge history is pinned high until the synchronizer holds a real sample,
  // so a button held through reset release never reads as a fresh press.
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      warm_q <= '0;
      hist_q <= '1;
      press_q <= '0;
    end else begin
      sync1_q <= {bus.button_2, bus.button_1};
      sync2_q <= sync1_q;
      warm_q <= {warm_q[0], 1'b1};
      hist_q <= warm_q[1] ? sync2_q : 2'b11;
      press_q <= sync2_q & ~hist_q;
    end

  assign last_beat = idx_q == 5'd31;

  always_comb begin
    state_d = state_q;
    notes1_d = notes1_q;
    notes2_d = notes2_q;
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    idx_d = idx_q;
    pend_d = pend_q;
    valid_d = valid_q;
    if (bus.abort) begin
      valid_d = 1'b0;
      if (state_q == ARMED || state_q == RECORD) begin
        state_d = IDLE;
        notes1_d = '0;
        notes2_d = '0;
        cnt1_d = '0;
        cnt2_d = '0;
        idx_d = '0;
        pend_d = '0;
      end
    end else begin
      case (state_q)
        IDLE:
          if (bus.start) begin
            state_d = ARMED;
            notes1_d = '0;
            notes2_d = '0;
            cnt1_d = '0;
            cnt2_d = '0;
            valid_d = 1'b0;
          end
        ARMED:
          if (bus.beat_clk) begin
            state_d = RECORD;
            idx_d = '0;
          end
        RECORD:
          if (bus.beat_clk) begin
            notes1_d[5'd31 - idx_q] = pend_q[0];
            notes2_d[5'd31 - idx_q] = pend_q[1];
            cnt1_d = pend_q[0] ? bcd_inc(cnt1_q) : cnt1_q;
            cnt2_d = pend_q[1] ? bcd_inc(cnt2_q) : cnt2_q;
            // a press on the boundary opens the next window; after the last beat there is none
            pend_d = last_beat ? 2'b00 : press_q;
            idx_d = last_beat ? 5'd0 : idx_q + 5'd1;
            state_d = last_beat ? DONE : RECORD;
            valid_d = last_beat;
          end else begin
            pend_d = pend_q | press_q;
          end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= IDLE;
      notes1_q <= '0;
      notes2_q <= '0;
      cnt1_q <= '0;
      cnt2_q <= '0;
      idx_q <= '0;
      pend_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      notes1_q <= notes1_d;
      notes2_q <= notes2_d;
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      valid_q <= valid_d;
    end

  assign bus.notes1 = notes1_q;
  assign bus.notes2 = notes2_q;
  assign bus.count_1 = cnt1_q;
  assign bus.count_2 = cnt2_q;
  assign bus.beat_idx = idx_q;
  assign bus.recording = state_q == ARMED || state_q == RECORD;
  assign bus.done = state_q == DONE;
  assign bus.notes_valid = valid_q;
endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder: randomized scoreboard bench for note_recorder
module tb_note_recorder;
  localparam int P = 10;
  localparam int B0 = 5;
  localparam int NC = B0 + 33 * P + 8;
  typedef struct {
    logic [31:0] n1, n2;
    logic [7:0] c1, c2;
  } exp_t;
  logic clk = 1'b0;
  logic n_rst;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic lv1 [NC];
  logic lv2 [NC];

  note_recorder_if bus ();
  note_recorder dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input logic [31:0] p);
    int n;
    n = $countones(p);
    return 8'((n / 10) * 16 + n % 10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " notes1"}, bus.notes1, 0);
    chk({tag, " notes2"}, bus.notes2, 0);
    chk({tag, " count_1"}, 32'(bus.count_1), 0);
    chk({tag, " count_2"}, 32'(bus.count_2), 0);
    chk({tag, " beat_idx"}, 32'(bus.beat_idx), 0);
    chk({tag, " recording"}, 32'(bus.recording), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " notes_valid"}, 32'(bus.notes_valid), 0);
  endtask

  // monitor: every done pulse must match the oldest expected recording
  always @(negedge clk)
    if (n_rst && bus.done) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected done: got done=1, want no done");
      end else begin
        e = sb.pop_front();
        chk("done notes1", bus.notes1, e.n1);
        chk("done notes2", bus.notes2, e.n2);
        chk("done count_1", 32'(bus.count_1), 32'(e.c1));
        chk("done count_2", 32'(bus.count_2), 32'(e.c2));
        chk("done notes_valid", 32'(bus.notes_valid), 1);
      end
    end

  task automatic set_lv(input int l, input int c);
    if (c >= 0 && c < NC) begin
      if (l == 1) lv2[c] = 1'b1;
      else lv1[c] = 1'b1;
    end
  endtask

  // raw rise 3 cycles ahead so the press pulse lands in cycle pc
  task automatic press_at(input int l, input int pc);
    set_lv(l, pc - 3);
    set_lv(l, pc - 2);
  endtask

  // mode 0: full recording, 1: abort after nb beats, 2: leave mid-recording
  task automatic run_rec(input logic [31:0] p1_i, input logic [31:0] p2_i, input int nb,
                         input int mode, input bit coin, input bit fin, input bit hold1);
    logic [31:0] p1, p2, p, m;
    int pc, ca, len, k;
    exp_t e;
    p1 = p1_i;
    p2 = p2_i;
    if (coin) begin
      p1[31] = 1'b0;
      p2[31] = 1'b0;
    end
    ca = B0 + (nb - 1) * P + 5;
    len = (mode == 1) ? ca + 2 : B0 + (nb - 1) * P + 3;
    for (int c = 0; c < NC; c++) begin
      lv1[c] = 1'b0;
      lv2[c] = 1'b0;
    end
    if (hold1) for (int c = 0; c <= B0 + 3 * P; c++) lv1[c] = 1'b1;
    else press_at(0, 3);
    press_at(1, 3);
    for (int l = 0; l < 2; l++) begin
      p = (l == 1) ? p2 : p1;
      for (int w = 0; w < 32; w++)
        if (p[31 - w]) begin
          pc = coin ? B0 + w * P : B0 + w * P + int'($urandom_range(1, 4));
          press_at(l, pc);
          if (!coin && $urandom_range(0, 1) == 1) press_at(l, pc + 4);
        end
      if (fin) press_at(l, B0 + 32 * P);
    end
    if (mode == 0) begin
      e.n1 = p1;
      e.n2 = p2;
      e.c1 = bcd(p1);
      e.c2 = bcd(p2);
      sb.push_back(e);
    end
    m = ~(32'hFFFF_FFFF >> (nb - 1));
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      bus.start = c == 0;
      bus.beat_clk = c >= B0 && (c - B0) % P == 0 && (c - B0) / P < nb;
      bus.abort = mode == 1 && c == ca;
      bus.button_1 = lv1[c];
      bus.button_2 = lv2[c];
      @(negedge clk);
      if (c == 1) begin
        chk("start notes1", bus.notes1, 0);
        chk("start notes2", bus.notes2, 0);
        chk("start count_1", 32'(bus.count_1), 0);
        chk("start count_2", 32'(bus.count_2), 0);
        chk("start notes_valid", 32'(bus.notes_valid), 0);
        chk("armed recording", 32'(bus.recording), 1);
      end
      if (c > B0 && (c - B0 - 1) % P == 0) begin
        k = (c - B0 - 1) / P;
        chk("recording", 32'(bus.recording), k < 32 ? 1 : 0);
        chk("beat_idx", 32'(bus.beat_idx), k < 32 ? k : 0);
      end
      if (mode == 0 && c == B0 + 32 * P + 2) begin
        chk("idle notes1 hold", bus.notes1, p1);
        chk("idle notes_valid", 32'(bus.notes_valid), 1);
        chk("done width", 32'(bus.done), 0);
      end
      if (mode == 1 && c == ca) begin
        chk("partial notes1", bus.notes1, p1 & m);
        chk("partial notes2", bus.notes2, p2 & m);
        chk("partial count_1", 32'(bus.count_1), 32'(bcd(p1 & m)));
      end
      if (mode == 1 && c == ca + 1) chk_zero("abort");
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.beat_clk = 1'b0;
    bus.button_1 = 1'b0;
    bus.button_2 = 1'b0;
    if (mode == 0) begin
      repeat (2) @(negedge clk);
      chk("done seen", sb.size(), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.beat_clk = 1'b0;
    bus.button_1 = 1'b0;
    bus.button_2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    run_rec(32'h8000_0001, 32'h0, 33, 0, 1'b0, 1'b0, 1'b0);
    run_rec($urandom, 32'hFFFF_FFFF, 33, 0, 1'b0, 1'b1, 1'b0);
    run_rec(32'h0400_0000, $urandom, 33, 0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.beat_clk = 1'b1;
    @(negedge clk);
    chk("start+abort recording", 32'(bus.recording), 0);
    chk("start+abort notes_valid", 32'(bus.notes_valid), 0);
    chk("start+abort notes1 hold", bus.notes1, 32'h0400_0000);
    @(posedge clk);
    #1;
    bus.beat_clk = 1'b0;
    @(negedge clk);
    chk("start+abort stays idle", 32'(bus.recording), 0);
    chk("start+abort beat_idx", 32'(bus.beat_idx), 0);
    repeat (4) run_rec($urandom, $urandom, 33, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    run_rec($urandom | 32'hFF80_0000, $urandom, 10, 1, 1'b0, 1'b0, 1'b0);
    run_rec($urandom, $urandom, 8, 2, 1'b0, 1'b0, 1'b0);
    bus.button_1 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset recording", 32'(bus.recording), 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk_zero("async reset");
    @(posedge clk);
    #1;
    chk_zero("reset held");
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    run_rec($urandom & 32'h03FF_FFFF, $urandom, 33, 0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
